// File: rtl/owm_byte_sequencer.sv
// owm_byte_sequencer
//   Byte-level command sequencer in front of the bit-level 1-wire master (owm).
//   It accepts RESET / WRITE_BYTE / READ_BYTE requests and issues one owm bit
//   command per bit slot, LSB first. It also keeps a running Dallas CRC8 over
//   every data bit it transfers.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 request handshake (valid/ready, op, data, bus)
//   rsp_*                 one-cycle response pulse; payload held until the next response
//   crc_o, crc_clr_i      running CRC8 and its synchronous clear
//   busy_o                transaction in progress
//   owm_*                 bit-level command interface to the owm core
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; ready only while owm is idle
// START  | one-cycle start pulse to owm with cmd/wrdat/addr
// SETTLE | owm drops ready one cycle after start; ready ignored here
// WAIT   | wait for owm ready, then consume the bit result
// DONE   | response pulse for a completed transaction
// ERR    | response pulse with error flag for an illegal op
module owm_byte_sequencer #(
    parameter  int OW_BUS_NUM = 4,
    localparam int OW_ADDR_W  = (OW_BUS_NUM == 1) ? 1 : $clog2(OW_BUS_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [7:0]           req_data_i,
    input  logic [OW_ADDR_W-1:0] req_bus_i,
    output logic                 rsp_valid_o,
    output logic [7:0]           rsp_data_o,
    output logic                 rsp_presence_o,
    output logic                 rsp_err_o,
    output logic [7:0]           crc_o,
    input  logic                 crc_clr_i,
    output logic                 busy_o,
    output logic                 owm_start_o,
    output logic [2:0]           owm_cmd_o,
    output logic [OW_ADDR_W-1:0] owm_ow_addr_o,
    output logic                 owm_wrdat_o,
    input  logic                 owm_ready_i,
    input  logic                 owm_rddat_i,
    input  logic                 owm_presence_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SETTLE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_ILL   = 2'd3;

    state_t                 state_q, state_d;
    logic [7:0]             shift_q;
    logic [7:0]             data_q;
    logic [1:0]             op_q;
    logic [OW_ADDR_W-1:0]   addr_q;
    logic [2:0]             bit_cnt_q;
    logic [2:0]             cmd_q;
    logic [7:0]             crc_q;
    logic [7:0]             rsp_data_q;
    logic                   rsp_pres_q;
    logic                   rsp_err_q;

    logic                   xfer;
    logic                   slot_done;
    logic                   last_bit;
    logic                   data_bit;
    logic                   crc_upd;
    logic [7:0]             crc_next;
    logic [7:0]             shift_next;

    assign req_ready_o = !rst_i && (state_q == S_IDLE) && owm_ready_i;
    assign xfer        = req_valid_i && req_ready_o;
    assign slot_done   = (state_q == S_WAIT) && owm_ready_i;
    assign last_bit    = (bit_cnt_q == 3'd7);

    // The bit fed to the CRC is the one that went out on the wire (write)
    // or the one that came back (read).
    assign data_bit    = (op_q == OP_READ) ? owm_rddat_i : shift_q[0];
    assign crc_upd     = slot_done && (op_q != OP_RESET);
    assign crc_next    = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ data_bit) ? 8'h8C : 8'h00);
    assign shift_next  = (op_q == OP_READ) ? {owm_rddat_i, shift_q[7:1]}
                                           : {1'b0, shift_q[7:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owm_start_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (xfer) begin
                    state_d = (req_op_i == OP_ILL) ? S_ERR : S_START;
                end
            end
            S_START: begin
                owm_start_o = 1'b1;
                state_d     = S_SETTLE;
            end
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (owm_ready_i) begin
                    state_d = ((op_q == OP_RESET) || last_bit) ? S_DONE : S_START;
                end
            end
            S_DONE: begin
                rsp_valid_o = 1'b1;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                rsp_valid_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            op_q       <= OP_RESET;
            addr_q     <= '0;
            bit_cnt_q  <= 3'd0;
            cmd_q      <= 3'd0;
            crc_q      <= 8'h00;
            rsp_data_q <= 8'h00;
            rsp_pres_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (xfer) begin
                if (req_op_i == OP_ILL) begin
                    rsp_data_q <= 8'h00;
                    rsp_pres_q <= 1'b0;
                    rsp_err_q  <= 1'b1;
                end else begin
                    op_q      <= req_op_i;
                    data_q    <= req_data_i;
                    addr_q    <= req_bus_i;
                    bit_cnt_q <= 3'd0;
                    // op encoding 0/1/2 maps directly onto owm cmd 0/1/2
                    cmd_q     <= {1'b0, req_op_i};
                    shift_q   <= (req_op_i == OP_WRITE) ? req_data_i : 8'h00;
                end
            end

            if (slot_done) begin
                if (op_q != OP_RESET) begin
                    shift_q <= shift_next;
                    if (!last_bit) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                if ((op_q == OP_RESET) || last_bit) begin
                    // Response payload is loaded on the edge into DONE so it
                    // is valid alongside the pulse and held afterwards.
                    case (op_q)
                        OP_READ:  rsp_data_q <= shift_next;
                        OP_WRITE: rsp_data_q <= data_q;
                        default:  rsp_data_q <= 8'h00;
                    endcase
                    rsp_pres_q <= (op_q == OP_RESET) && owm_presence_i;
                    rsp_err_q  <= 1'b0;
                end
            end

            // Clear has priority over a coincident bit update.
            if (crc_clr_i) begin
                crc_q <= 8'h00;
            end else if (crc_upd) begin
                crc_q <= crc_next;
            end
        end
    end

    assign crc_o          = crc_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_presence_o = rsp_pres_q;
    assign rsp_err_o      = rsp_err_q;
    assign owm_cmd_o      = cmd_q;
    assign owm_ow_addr_o  = addr_q;
    assign owm_wrdat_o    = shift_q[0];

endmodule

// File: tb/tb_owm_byte_sequencer.sv
module tb_owm_byte_sequencer;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_data = 8'h00;
    logic [1:0] req_bus = 2'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       rsp_err;
    logic [7:0] crc;
    logic       crc_clr = 1'b0;
    logic       busy;
    logic       owm_start;
    logic [2:0] owm_cmd;
    logic [1:0] owm_addr;
    logic       owm_wrdat;
    logic       owm_ready;
    logic       m_rddat = 1'b0;
    logic       m_presence = 1'b0;

    // owm bit-slot model state
    logic       m_rdy = 1'b1;
    logic       m_hold = 1'b0;
    logic       m_drop = 1'b0;
    int         m_cnt = 0;
    int         m_lat = 1;
    logic [2:0] m_cur_cmd = 3'd0;
    logic [7:0] m_rd_byte = 8'h00;
    logic [2:0] m_bit = 3'd0;

    logic [2:0] log_cmd  [0:255];
    logic       log_wr   [0:255];
    logic [1:0] log_addr [0:255];
    int         log_cyc  [0:255];
    int         n_starts = 0;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_rsp = 0;
    int         rsp_cyc = 0;
    int         drive_cyc = 0;
    int         cyc = 0;
    logic [7:0] tb_crc = 8'h00;

    assign owm_ready = m_rdy && !m_hold;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    owm_byte_sequencer #(.OW_BUS_NUM(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_data_i     (req_data),
        .req_bus_i      (req_bus),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .rsp_presence_o (rsp_presence),
        .rsp_err_o      (rsp_err),
        .crc_o          (crc),
        .crc_clr_i      (crc_clr),
        .busy_o         (busy),
        .owm_start_o    (owm_start),
        .owm_cmd_o      (owm_cmd),
        .owm_ow_addr_o  (owm_addr),
        .owm_wrdat_o    (owm_wrdat),
        .owm_ready_i    (owm_ready),
        .owm_rddat_i    (m_rddat),
        .owm_presence_i (m_presence)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p, input logic e);
        exp_t r;
        r.d = d;
        r.p = p;
        r.e = e;
        return r;
    endfunction

    function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = (r >> 1) ^ (fb ? 8'h8C : 8'h00);
        end
        return r;
    endfunction

    // owm model: ready drops the cycle after start, rises m_lat cycles later
    always @(negedge clk) begin
        if (rst) begin
            m_rdy  = 1'b1;
            m_drop = 1'b0;
            m_cnt  = 0;
        end else begin
            if (m_drop) begin
                m_rdy  = 1'b0;
                m_drop = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (m_cur_cmd == 3'd2) begin
                        m_rddat = m_rd_byte[m_bit];
                        m_bit   = m_bit + 3'd1;
                    end
                    m_rdy = 1'b1;
                end
            end
            if (owm_start) begin
                if (n_starts < 256) begin
                    log_cmd[n_starts]  = owm_cmd;
                    log_wr[n_starts]   = owm_wrdat;
                    log_addr[n_starts] = owm_addr;
                    log_cyc[n_starts]  = cyc;
                    n_starts++;
                end
                m_cur_cmd = owm_cmd;
                m_drop    = 1'b1;
                m_cnt     = m_lat;
            end
        end
    end

    // response monitor / scoreboard pop
    always @(negedge clk) begin
        if (rsp_valid) begin
            exp_t e;
            n_rsp++;
            rsp_cyc = cyc;
            chk("rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_presence", rsp_presence, e.p);
                chk("rsp_err", rsp_err, e.e);
            end
            chk("busy_in_rsp", busy, 1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [1:0] bus, input exp_t e);
        int k;
        k = 0;
        while (!req_ready && k < 200) begin
            tick();
            k++;
        end
        chk("req_ready_wait", req_ready, 1);
        sb.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_bus   = bus;
        drive_cyc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int k;
        k = 0;
        while (n_rsp < target && k < 500) begin
            tick();
            k++;
        end
        chk("rsp_timeout", n_rsp >= target, 1);
    endtask

    // count start pulses (already seen = have) until total reaches want
    task automatic wait_starts(input int have, input int want);
        int c;
        int k;
        c = have;
        k = 0;
        while (c < want && k < 200) begin
            tick();
            if (owm_start) c++;
            k++;
        end
        chk("start_count_wait", c, want);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        logic [7:0] wb;
        logic [7:0] rom [8];
        rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_ready", req_ready, 0);
        chk("reset_flags", {rsp_valid, rsp_presence, rsp_err, busy, owm_start, owm_wrdat}, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_crc", crc, 0);
        chk("reset_cmd_addr", {owm_cmd, owm_addr}, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", req_ready, 1);

        // RESET on bus 2, presence 1
        m_presence = 1'b1;
        s0 = n_starts;
        r0 = n_rsp;
        send(2'd0, 8'h5A, 2'd2, mk(8'h00, 1'b1, 1'b0));
        wait_rsp(r0 + 1);
        chk("reset_op_starts", n_starts - s0, 1);
        chk("reset_op_cmd", log_cmd[s0], 0);
        chk("reset_op_addr", log_addr[s0], 2);
        chk("reset_op_crc", crc, tb_crc);

        // WRITE_BYTE 0xCC on bus 1
        wb = 8'hCC;
        s0 = n_starts;
        r0 = n_rsp;
        send(2'd1, wb, 2'd1, mk(wb, 1'b0, 1'b0));
        wait_rsp(r0 + 1);
        tb_crc = crc_byte(tb_crc, wb);
        chk("write_starts", n_starts - s0, 8);
        chk("write_first_start_latency", log_cyc[s0], drive_cyc + 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("write_cmd[%0d]", i), log_cmd[s0+i], 1);
            chk($sformatf("write_wrdat[%0d]", i), log_wr[s0+i], wb[i]);
            chk($sformatf("write_addr[%0d]", i), log_addr[s0+i], 1);
            if (i > 0) chk($sformatf("write_slot_cycles[%0d]", i), log_cyc[s0+i] - log_cyc[s0+i-1], 3);
        end
        chk("write_rsp_latency", rsp_cyc, log_cyc[s0+7] + 3);
        chk("write_crc", crc, tb_crc);
        chk("busy_after_write", busy, 0);

        // CRC clear then eight READ_BYTEs of a ROM id
        crc_clr = 1'b1;
        tick();
        crc_clr = 1'b0;
        chk("crc_clr", crc, 0);
        tb_crc = 8'h00;
        m_presence = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_rd_byte = rom[i];
            m_bit = 3'd0;
            s0 = n_starts;
            r0 = n_rsp;
            send(2'd2, 8'h00, 2'd0, mk(rom[i], 1'b0, 1'b0));
            wait_rsp(r0 + 1);
            tb_crc = crc_byte(tb_crc, rom[i]);
            chk($sformatf("read_starts[%0d]", i), n_starts - s0, 8);
            chk($sformatf("read_cmd[%0d]", i), log_cmd[s0], 2);
            chk($sformatf("read_crc[%0d]", i), crc, tb_crc);
            if (i == 6) chk("rom_crc_value", crc, 8'hA2);
            if (i == 7) chk("rom_crc_residue", crc, 8'h00);
        end

        // illegal op
        s0 = n_starts;
        r0 = n_rsp;
        send(2'd3, 8'hFF, 2'd3, mk(8'h00, 1'b0, 1'b1));
        wait_rsp(r0 + 1);
        chk("err_no_start", n_starts - s0, 0);
        chk("err_latency", rsp_cyc, drive_cyc + 1);
        chk("err_crc_unchanged", crc, tb_crc);

        // reset in bit 4 of a READ_BYTE
        m_rd_byte = 8'h96;
        m_bit = 3'd0;
        r0 = n_rsp;
        send(2'd2, 8'h00, 2'd1, mk(8'h96, 1'b0, 1'b0));
        wait_starts(1, 5);
        rst = 1'b1;
        tick();
        chk("midrst_start", owm_start, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_crc", crc, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready_in_rst", req_ready, 0);
        sb.delete();
        tb_crc = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_ready_after", req_ready, 1);
        chk("midrst_no_rsp", n_rsp, r0);
        wb = 8'h5A;
        s0 = n_starts;
        send(2'd1, wb, 2'd3, mk(wb, 1'b0, 1'b0));
        wait_rsp(r0 + 1);
        tb_crc = crc_byte(tb_crc, wb);
        chk("postrst_starts", n_starts - s0, 8);
        chk("postrst_crc", crc, tb_crc);

        // crc clear coincident with the final bit update
        r0 = n_rsp;
        send(2'd1, 8'hFF, 2'd0, mk(8'hFF, 1'b0, 1'b0));
        wait_starts(1, 8);
        tick();             // SETTLE
        tick();             // WAIT, ready high at this edge's end
        crc_clr = 1'b1;
        tick();
        crc_clr = 1'b0;
        wait_rsp(r0 + 1);
        chk("clr_wins_crc", crc, 0);
        tb_crc = 8'h00;

        // owm busy in IDLE blocks requests
        m_hold = 1'b1;
        tick();
        chk("hold_ready", req_ready, 0);
        r0 = n_rsp;
        s0 = n_starts;
        sb.push_back(mk(8'h00, 1'b0, 1'b0));
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_data  = 8'h00;
        req_bus   = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hold_ready[%0d]", i), req_ready, 0);
            chk($sformatf("hold_busy[%0d]", i), busy, 0);
        end
        m_hold = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("hold_accept_busy", busy, 1);
        chk("hold_accept_start", owm_start, 1);
        wait_rsp(r0 + 1);
        chk("hold_starts", n_starts - s0, 1);
        chk("hold_addr", log_addr[s0], 3);
        chk("hold_crc", crc, tb_crc);
        chk("sb_empty", sb.size(), 0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
